// File: rtl/branch_unit_pkg.sv
// Shared definitions for the branch unit.
//   - state_e      : FSM states (run / one-cycle flush / halt)
//   - Cond*        : cond_code encodings; 6 and 7 both decode as never-true
//   - PcWidth      : program counter width
//   - CntWidth/Max : taken-jump counter width and saturation value
package branch_unit_pkg;

  localparam int unsigned PcWidth  = 8;
  localparam int unsigned CntWidth = 8;
  localparam logic [CntWidth-1:0] CntMax = '1;

  localparam logic [2:0] CondEq    = 3'd0;
  localparam logic [2:0] CondNe    = 3'd1;
  localparam logic [2:0] CondLt    = 3'd2;
  localparam logic [2:0] CondLe    = 3'd3;
  localparam logic [2:0] CondGt    = 3'd4;
  localparam logic [2:0] CondGe    = 3'd5;
  localparam logic [2:0] CondNever = 3'd6;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StFlush = 2'd1,
    StHalt  = 2'd2
  } state_e;

endpackage

// File: rtl/branch_unit_if.sv
// Instruction/status bundle between an issuing stage and the branch unit.
//   master : drives the instruction fields, stall and resume; observes status
//   slave  : the branch unit; returns ready, pc, taken, flush, halted, taken_cnt
interface branch_unit_if;
  import branch_unit_pkg::*;

  logic                instr_valid;
  logic                is_cond;
  logic                is_halt;
  logic [2:0]          cond_code;
  logic [7:0]          arg1;
  logic [7:0]          arg2;
  logic [PcWidth-1:0]  target;
  logic                stall;
  logic                resume;

  logic                ready;
  logic [PcWidth-1:0]  pc;
  logic                taken;
  logic                flush;
  logic                halted;
  logic [CntWidth-1:0] taken_cnt;

  modport master (
    output instr_valid, is_cond, is_halt, cond_code, arg1, arg2, target, stall, resume,
    input  ready, pc, taken, flush, halted, taken_cnt
  );

  modport slave (
    input  instr_valid, is_cond, is_halt, cond_code, arg1, arg2, target, stall, resume,
    output ready, pc, taken, flush, halted, taken_cnt
  );

endinterface

// File: rtl/branch_unit_cond_eval.sv
// Combinational condition evaluator for conditional jumps.
//   i_cond_code : condition select (EQ, NE, LT, LE, GT, GE, never)
//   i_arg1/2    : unsigned operands
//   o_true      : selected condition holds for i_arg1 vs i_arg2
module cond_eval
  import branch_unit_pkg::*;
#(
  parameter int unsigned UUID = 0
) (
  input  logic [2:0] i_cond_code,
  input  logic [7:0] i_arg1,
  input  logic [7:0] i_arg2,
  output logic       o_true
);

  logic w_eq;
  logic w_lt;

  assign w_eq = (i_arg1 == i_arg2);
  assign w_lt = (i_arg1 < i_arg2);

  always_comb begin
    o_true = 1'b0;
    case (i_cond_code)
      CondEq:  o_true = w_eq;
      CondNe:  o_true = !w_eq;
      CondLt:  o_true = w_lt;
      CondLe:  o_true = w_lt | w_eq;
      CondGt:  o_true = !(w_lt | w_eq);
      CondGe:  o_true = !w_lt;
      default: o_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Branch unit: program counter, conditional-jump resolution and halt control.
//   clk    : clock, all state on rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : branch_unit_if slave modport
//            in : instr_valid, is_cond, is_halt, cond_code, arg1, arg2, target, stall, resume
//            out: ready, pc, taken, flush, halted, taken_cnt
// A taken jump loads target and spends one FLUSH cycle; a halt advances pc and
// parks in HALT until resume.
module branch_unit
  import branch_unit_pkg::*;
#(
  parameter int unsigned UUID = 0,
  parameter string       NAME = ""
) (
  input logic          clk,
  input logic          rst_n,
  branch_unit_if.slave bus
);

  state_e              r_state;
  state_e              w_state_d;
  logic [PcWidth-1:0]  r_pc;
  logic [PcWidth-1:0]  w_pc_d;
  logic                r_taken;
  logic                w_taken_d;
  logic [CntWidth-1:0] r_taken_cnt;
  logic [CntWidth-1:0] w_taken_cnt_d;

  logic w_ready;
  logic w_accept;
  logic w_cond_true;

  cond_eval #(
    .UUID (UUID ^ 32'h0000_0001)
  ) u_cond_eval (
    .i_cond_code (bus.cond_code),
    .i_arg1      (bus.arg1),
    .i_arg2      (bus.arg2),
    .o_true      (w_cond_true)
  );

  assign w_ready  = (r_state == StRun) && !bus.stall;
  assign w_accept = w_ready && bus.instr_valid;

  always_comb begin
    w_state_d     = r_state;
    w_pc_d        = r_pc;
    w_taken_d     = 1'b0;
    w_taken_cnt_d = r_taken_cnt;
    unique case (r_state)
      StRun: begin
        if (w_accept) begin
          // is_cond wins over is_halt; a false condition falls through as a plain op.
          if (bus.is_cond && w_cond_true) begin
            w_pc_d    = bus.target;
            w_taken_d = 1'b1;
            w_state_d = StFlush;
            if (r_taken_cnt != CntMax) begin
              w_taken_cnt_d = r_taken_cnt + 1'b1;
            end
          end else begin
            w_pc_d = r_pc + 1'b1;
            if (bus.is_halt && !bus.is_cond) begin
              w_state_d = StHalt;
            end
          end
        end
      end
      StFlush: w_state_d = StRun;
      StHalt: begin
        if (bus.resume) begin
          w_state_d = StRun;
        end
      end
      default: w_state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StRun;
      r_pc        <= '0;
      r_taken     <= 1'b0;
      r_taken_cnt <= '0;
    end else begin
      r_state     <= w_state_d;
      r_pc        <= w_pc_d;
      r_taken     <= w_taken_d;
      r_taken_cnt <= w_taken_cnt_d;
    end
  end

  assign bus.ready     = w_ready;
  assign bus.pc        = r_pc;
  assign bus.taken     = r_taken;
  assign bus.flush     = (r_state == StFlush);
  assign bus.halted    = (r_state == StHalt);
  assign bus.taken_cnt = r_taken_cnt;

endmodule

// File: tb/tb_branch_unit.sv
// Directed self-checking bench for branch_unit.
module tb_branch_unit;
  import branch_unit_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  branch_unit_if bus ();

  branch_unit #(
    .UUID (0),
    .NAME ("tb")
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.instr_valid = 1'b0;
    bus.is_cond     = 1'b0;
    bus.is_halt     = 1'b0;
    bus.cond_code   = 3'd0;
    bus.arg1        = 8'd0;
    bus.arg2        = 8'd0;
    bus.target      = 8'd0;
  endtask

  task automatic plain();
    idle();
    bus.instr_valid = 1'b1;
  endtask

  task automatic jump(input logic [2:0] code, input logic [7:0] a1, input logic [7:0] a2,
                      input logic [7:0] tgt);
    plain();
    bus.is_cond   = 1'b1;
    bus.cond_code = code;
    bus.arg1      = a1;
    bus.arg2      = a2;
    bus.target    = tgt;
  endtask

  task automatic halt();
    plain();
    bus.is_halt = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n      = 1'b0;
    bus.stall  = 1'b0;
    bus.resume = 1'b0;
    idle();
    #2;
    check("rst_pc", 32'(bus.pc), 32'h00);
    check("rst_taken", 32'(bus.taken), 32'd0);
    check("rst_flush", 32'(bus.flush), 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_cnt", 32'(bus.taken_cnt), 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd1);
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;

    // Plain instructions from the first cycle after reset
    plain();
    step(); check("plain_pc1", 32'(bus.pc), 32'h01); check("plain_tk1", 32'(bus.taken), 32'd0);
    step(); check("plain_pc2", 32'(bus.pc), 32'h02); check("plain_tk2", 32'(bus.taken), 32'd0);
    step(); check("plain_pc3", 32'(bus.pc), 32'h03); check("plain_tk3", 32'(bus.taken), 32'd0);
    step();
    step(); check("plain_pc5", 32'(bus.pc), 32'h05);

    // LT 3<7 taken from pc=5
    jump(CondLt, 8'd3, 8'd7, 8'h40);
    step();
    check("lt_pc", 32'(bus.pc), 32'h40);
    check("lt_taken", 32'(bus.taken), 32'd1);
    check("lt_flush", 32'(bus.flush), 32'd1);
    check("lt_ready", 32'(bus.ready), 32'd0);
    check("lt_cnt", 32'(bus.taken_cnt), 32'd1);
    plain();
    step();
    check("fl_pc_hold", 32'(bus.pc), 32'h40);
    check("fl_taken_off", 32'(bus.taken), 32'd0);
    check("fl_flush_off", 32'(bus.flush), 32'd0);
    check("fl_ready", 32'(bus.ready), 32'd1);

    // Not-taken conditions
    jump(CondGt, 8'd9, 8'd9, 8'hAA);
    step();
    check("gt_eq_pc", 32'(bus.pc), 32'h41);
    check("gt_eq_tk", 32'(bus.taken), 32'd0);
    check("gt_eq_fl", 32'(bus.flush), 32'd0);
    jump(CondNever, 8'd0, 8'd0, 8'hAA);
    step(); check("c6_pc", 32'(bus.pc), 32'h42);
    jump(3'd7, 8'd200, 8'd1, 8'hAA);
    step(); check("c7_pc", 32'(bus.pc), 32'h43); check("c7_tk", 32'(bus.taken), 32'd0);
    check("nt_cnt", 32'(bus.taken_cnt), 32'd1);

    // Remaining condition codes
    jump(CondEq, 8'd5, 8'd5, 8'h80);
    step(); check("eq_pc", 32'(bus.pc), 32'h80); check("eq_tk", 32'(bus.taken), 32'd1);
    plain(); step();
    jump(CondNe, 8'd5, 8'd5, 8'hAA);
    step(); check("ne_f_pc", 32'(bus.pc), 32'h81);
    jump(CondGe, 8'd9, 8'd9, 8'h90);
    step(); check("ge_pc", 32'(bus.pc), 32'h90);
    plain(); step();
    jump(CondLe, 8'd8, 8'd7, 8'hAA);
    step(); check("le_f_pc", 32'(bus.pc), 32'h91);
    jump(CondLe, 8'd7, 8'd7, 8'hA0);
    step(); check("le_pc", 32'(bus.pc), 32'hA0);
    plain(); step();
    jump(CondNe, 8'd1, 8'd2, 8'hFF);
    step(); check("ne_pc", 32'(bus.pc), 32'hFF);
    plain(); step();
    check("ff_hold", 32'(bus.pc), 32'hFF);
    step();
    check("wrap_pc", 32'(bus.pc), 32'h00);
    check("cnt5", 32'(bus.taken_cnt), 32'd5);

    // Stall blocks acceptance
    bus.stall = 1'b1;
    plain();
    #1;
    check("stall_ready", 32'(bus.ready), 32'd0);
    step(); check("stall_pc", 32'(bus.pc), 32'h00);
    step(); check("stall_pc2", 32'(bus.pc), 32'h00);
    bus.stall = 1'b0;
    #1;
    check("unstall_ready", 32'(bus.ready), 32'd1);

    // resume outside HALT has no effect
    idle();
    bus.resume = 1'b1;
    step();
    check("res_ign_halted", 32'(bus.halted), 32'd0);
    check("res_ign_pc", 32'(bus.pc), 32'h00);
    bus.resume = 1'b0;

    // FLUSH exits even under stall
    jump(CondEq, 8'd1, 8'd1, 8'h0A);
    step(); check("j10_pc", 32'(bus.pc), 32'h0A);
    bus.stall = 1'b1;
    plain();
    step();
    check("fl_stall_exit", 32'(bus.flush), 32'd0);
    check("fl_stall_rdy", 32'(bus.ready), 32'd0);
    bus.stall = 1'b0;

    // Halt at pc=10
    halt();
    step();
    check("halt_pc", 32'(bus.pc), 32'h0B);
    check("halt_flag", 32'(bus.halted), 32'd1);
    check("halt_ready", 32'(bus.ready), 32'd0);
    plain();
    repeat (5) step();
    check("halt_hold_pc", 32'(bus.pc), 32'h0B);
    check("halt_hold", 32'(bus.halted), 32'd1);
    idle();
    bus.resume = 1'b1;
    step();
    bus.resume = 1'b0;
    check("resume_halted", 32'(bus.halted), 32'd0);
    check("resume_ready", 32'(bus.ready), 32'd1);
    check("resume_pc", 32'(bus.pc), 32'h0B);

    // is_cond has priority over is_halt
    jump(CondEq, 8'd2, 8'd2, 8'h20);
    bus.is_halt = 1'b1;
    step();
    check("prio_t_pc", 32'(bus.pc), 32'h20);
    check("prio_t_fl", 32'(bus.flush), 32'd1);
    check("prio_t_hlt", 32'(bus.halted), 32'd0);
    plain(); step();
    jump(CondNe, 8'd2, 8'd2, 8'h33);
    bus.is_halt = 1'b1;
    step();
    check("prio_f_pc", 32'(bus.pc), 32'h21);
    check("prio_f_hlt", 32'(bus.halted), 32'd0);
    check("prio_f_rdy", 32'(bus.ready), 32'd1);

    // Jump to pc+1 still counts
    jump(CondEq, 8'd0, 8'd0, 8'h22);
    step();
    check("jp1_pc", 32'(bus.pc), 32'h22);
    check("jp1_tk", 32'(bus.taken), 32'd1);
    check("jp1_fl", 32'(bus.flush), 32'd1);
    check("jp1_cnt", 32'(bus.taken_cnt), 32'd8);

    // Reset during FLUSH
    jump(CondEq, 8'd0, 8'd0, 8'h50);
    plain(); step();
    jump(CondEq, 8'd0, 8'd0, 8'h50);
    step();
    check("pre_rst_fl", 32'(bus.flush), 32'd1);
    idle();
    #2 rst_n = 1'b0;
    #1;
    check("rstfl_flush", 32'(bus.flush), 32'd0);
    check("rstfl_pc", 32'(bus.pc), 32'h00);
    check("rstfl_taken", 32'(bus.taken), 32'd0);
    check("rstfl_cnt", 32'(bus.taken_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during HALT
    halt();
    step();
    check("h2_halted", 32'(bus.halted), 32'd1);
    check("h2_pc", 32'(bus.pc), 32'h01);
    idle();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("rsth_pc", 32'(bus.pc), 32'h00);
    check("rsth_halted", 32'(bus.halted), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Saturation over 260 taken jumps
    for (int i = 0; i < 260; i++) begin
      jump(CondEq, 8'd0, 8'd0, 8'h00);
      step();
      idle();
      step();
      if (i == 253) check("sat_254", 32'(bus.taken_cnt), 32'd254);
      if (i == 254) check("sat_255", 32'(bus.taken_cnt), 32'd255);
    end
    check("sat_final", 32'(bus.taken_cnt), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 Parameter UUID, default 0, instance identifier, XORed into sub-module UUIDs.
REQ-002 Parameter NAME, default "", instance label with no functional effect.
REQ-003 The block SHALL provide port clk, input, 1 bit, the single clock; all state on rising edge.
REQ-004 The block SHALL provide port rst, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL provide port instr_valid, input, 1 bit, instruction presented this cycle.
REQ-006 The block SHALL provide port is_cond, input, 1 bit, presented instruction is a conditional jump.
REQ-007 The block SHALL provide port is_halt, input, 1 bit, presented instruction is a halt.
REQ-008 The block SHALL provide port cond_code, input, 3 bits, condition select with bit weights 4/2/1.
REQ-009 The block SHALL provide ports arg1 and arg2, input, 8 bits each, unsigned comparison operands.
REQ-010 The block SHALL provide port target, input, 8 bits, jump destination.
REQ-011 The block SHALL provide port stall, input, 1 bit, downstream backpressure.
REQ-012 The block SHALL provide port resume, input, 1 bit, leave HALT.
REQ-013 The block SHALL provide port ready, output, 1 bit, instruction is accepted this cycle when ready and instr_valid are both 1.
REQ-014 The block SHALL provide port pc, output, 8 bits, registered program counter.
REQ-015 The block SHALL provide port taken, output, 1 bit, registered pulse one cycle after a taken jump.
REQ-016 The block SHALL provide port flush, output, 1 bit, high while in FLUSH.
REQ-017 The block SHALL provide port halted, output, 1 bit, high while in HALT.
REQ-018 The block SHALL provide port taken_cnt, output, 8 bits, saturating count of taken jumps.

Function
REQ-019 The block SHALL implement states RUN, FLUSH and HALT.
REQ-020 The block SHALL drive ready = (state==RUN) & !stall, combinationally.
REQ-021 The condition SHALL decode as: 0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE, 6 and 7 never true.
REQ-022 The condition SHALL be evaluated unsigned, combinationally, on the arg1 and arg2 values present in the accept cycle.
REQ-023 Accepted non-jump, non-halt instruction: pc SHALL become pc+1 modulo 256, so 255 wraps to 0.
REQ-024 Accepted is_cond with a true condition: pc SHALL become target, taken SHALL be 1 in the next cycle only, the state SHALL go to FLUSH, and taken_cnt SHALL increment, saturating at 255.
REQ-025 Accepted is_cond with a false condition: behaviour SHALL be that of REQ-023.
REQ-026 FLUSH SHALL last exactly one cycle: flush=1, ready=0, pc held, then RUN regardless of stall.
REQ-027 Accepted is_halt with is_cond=0: pc SHALL become pc+1 and the state SHALL go to HALT.
REQ-028 If is_cond and is_halt are both set, is_cond SHALL take priority and is_halt SHALL be ignored.
REQ-029 In HALT, ready SHALL be 0 and pc held; resume=1 SHALL move to RUN on the next edge.
REQ-030 resume SHALL be ignored outside HALT.
REQ-031 When not accepted (instr_valid=0, stall=1, or state!=RUN), pc, taken_cnt and state SHALL hold, except for the FLUSH/HALT exits above.
REQ-032 A jump to target==pc+1 SHALL still count as taken and still enter FLUSH.

Reset
REQ-033 rst low SHALL immediately force: state RUN, pc 0, taken 0, flush 0, halted 0, taken_cnt 0.
REQ-034 Reset asserted mid-FLUSH or mid-HALT SHALL abandon that state without finishing it.
REQ-035 The first instruction SHALL be acceptable in the first cycle after rst rises.

Structure
REQ-036 A shared package SHALL hold the state enum, the cond_code localparams (EQ..GE, NEVER), and the PC width constant 8.
REQ-037 Condition evaluation SHALL be one sub-module, cond_eval (cond_code, arg1, arg2 -> true), and the FSM, PC and counter SHALL be in branch_unit.

Verification
REQ-038 Bench: reset, then 3 accepted plain instructions -> pc 0,1,2,3; taken stays 0.
REQ-039 Bench: pc=5, is_cond, code 2, arg1=3, arg2=7, target=0x40 -> next pc=0x40, taken 1 for one cycle, flush 1 for one cycle, taken_cnt=1.
REQ-040 Bench: code 4 with arg1=arg2=9 -> not taken, pc+1; code 6 or 7 with any args -> not taken.
REQ-041 Bench: pc=255, plain instruction accepted -> pc=0; stall=1 with instr_valid=1 -> pc unchanged, ready=0.
REQ-042 Bench: is_halt accepted at pc=10 -> pc=11 and halted=1; instr_valid held high for 5 cycles -> pc stays 11; resume pulse -> RUN; rst low during HALT -> pc=0, halted=0.
REQ-043 Bench: 260 taken jumps -> taken_cnt=255, saturated.
